// File: rtl/dmem_if.sv
// MEM-stage data-memory bus between the core (master) and the responder (slave).
// Carries the request strobes, address/store data, read data and stall.
interface dmem_if;
  logic [15:0] Addr;
  logic [15:0] WrData;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] RdData;
  logic        RdValid;
  logic        Stall;

  modport master (
    output Addr, WrData, MemRead, MemWrite,
    input  RdData, RdValid, Stall
  );

  modport slave (
    input  Addr, WrData, MemRead, MemWrite,
    output RdData, RdValid, Stall
  );
endinterface

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: word RAM with WAIT_STATES access latency.
// Define DMEM_POSTED_WRITE_EN to add a one-entry posted write buffer.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input logic   Clk,
  input logic   Rst,
  dmem_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int W = WAIT_STATES;
  localparam logic [3:0] CNT0 = 4'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_DONE
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [15:0]       rdata_q;
  logic              wr_q;
  logic [15:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] a_in;
  logic              idle;
  logic              rd_req;
  logic              wr_req;
  logic              start;
  logic              busy;
  logic              direct_wr;
  logic              rd_valid;
  logic [15:0]       rd_word;
  logic              unused_addr;

  assign a_in = bus.Addr[ADDR_W-1:0];
  assign unused_addr = ^bus.Addr[15:ADDR_W];
  assign idle = (state_q == S_IDLE);
  // A write strobe wins over a simultaneous read strobe
  assign wr_req = idle & bus.MemWrite;
  assign rd_req = idle & bus.MemRead & ~bus.MemWrite;
  assign direct_wr = (W == 0) & wr_req;

`ifdef DMEM_POSTED_WRITE_EN
  logic              pb_v_q;
  logic [ADDR_W-1:0] pb_a_q;
  logic [15:0]       pb_d_q;
  logic [3:0]        pb_cnt_q;
  logic              pb_take;

  assign start = (W != 0) & rd_req;
  assign pb_take = (W != 0) & wr_req & ~pb_v_q;
  assign busy = (W != 0) & wr_req & pb_v_q;
  assign rd_word = (W == 0) ? mem_q[a_in] :
    (pb_v_q && pb_a_q == addr_q) ? pb_d_q :
    mem_q[addr_q];
`else
  assign start = (W != 0) & (rd_req | wr_req);
  assign busy = 1'b0;
  assign rd_word = (W == 0) ? mem_q[a_in] : mem_q[addr_q];
`endif

  assign rd_valid = (W == 0) ? rd_req :
    (state_q == S_DONE) & ~wr_q;

  assign bus.Stall = start | busy | (state_q == S_WAIT);
  assign bus.RdValid = rd_valid;
  assign bus.RdData = rd_valid ? rd_word : rdata_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef DMEM_POSTED_WRITE_EN
      pb_v_q   <= 1'b0;
      pb_a_q   <= '0;
      pb_d_q   <= '0;
      pb_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q  <= a_in;
            wdata_q <= bus.WrData;
            wr_q    <= bus.MemWrite;
            cnt_q   <= CNT0;
            state_q <= (W == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_DONE;
        end
        S_DONE: begin
          if (wr_q) mem_q[addr_q] <= wdata_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (direct_wr) mem_q[a_in] <= bus.WrData;
      if (rd_valid) rdata_q <= rd_word;
`ifdef DMEM_POSTED_WRITE_EN
      // Entry stays visible for forwarding through its commit cycle
      if (pb_v_q) begin
        pb_cnt_q <= pb_cnt_q - 4'd1;
        if (pb_cnt_q == 4'd1) begin
          mem_q[pb_a_q] <= pb_d_q;
          pb_v_q <= 1'b0;
        end
      end else if (pb_take) begin
        pb_v_q   <= 1'b1;
        pb_a_q   <= a_in;
        pb_d_q   <= bus.WrData;
        pb_cnt_q <= 4'(W);
      end
`endif
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (ADDR_W=8, WAIT_STATES=2).
// Posted-write checks build only with DMEM_POSTED_WRITE_EN.
module tb_dmem_responder;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  dmem_if bus();

  dmem_responder #(
    .ADDR_W(8),
    .WAIT_STATES(2)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

`ifdef DMEM_POSTED_WRITE_EN
  localparam int WR_ST = 0;
`else
  localparam int WR_ST = 2;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (bus.RdValid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got RdValid=1 data %0h, expected none",
                 bus.RdData);
      end else begin
        chk("rd_data", {16'h0, bus.RdData}, {16'h0, sb.pop_front()});
      end
    end
  end

  // Issue one access and follow it to its accept/DONE cycle
  task automatic access(input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] ed, input int exp_st,
                        input bit scr, input string nm);
    int st;
    st = 0;
    @(posedge Clk); #1;
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.Addr     = a;
    bus.WrData   = d;
    if (rd && !wr) sb.push_back(ed);
    #1;
    while (bus.Stall === 1'b1 && st <= 40) begin
      st++;
      @(posedge Clk); #1;
      if (scr) begin
        bus.Addr   = ~a;
        bus.WrData = ~d;
      end
      #1;
    end
    chk({nm, " stall"}, st, exp_st);
    chk({nm, " valid"}, {31'h0, bus.RdValid}, {31'h0, rd && !wr});
  endtask

  task automatic idle_hold(input logic [15:0] ed);
    @(posedge Clk); #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Addr     = 16'h00AA;
    #1;
    chk("idle stall", {31'h0, bus.Stall}, 32'h0);
    chk("idle valid", {31'h0, bus.RdValid}, 32'h0);
    chk("idle hold", {16'h0, bus.RdData}, {16'h0, ed});
  endtask

  initial begin
    Rst = 1'b1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Addr     = '0;
    bus.WrData   = '0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    chk("rst stall", {31'h0, bus.Stall}, 32'h0);
    chk("rst valid", {31'h0, bus.RdValid}, 32'h0);
    chk("rst rddata", {16'h0, bus.RdData}, 32'h0);

    access(1, 0, 16'h0005, 16'h0000, 16'h0000, 2, 0, "rd05");
    access(0, 1, 16'h0012, 16'hBEEF, 16'h0000, WR_ST, 1, "wr12");
    access(1, 0, 16'h0012, 16'h0000, 16'hBEEF, 2, 1, "rd12");
    idle_hold(16'hBEEF);
    access(0, 1, 16'h0107, 16'h1234, 16'h0000, WR_ST, 0, "wr107");
    access(1, 0, 16'h0007, 16'h0000, 16'h1234, 2, 0, "rd07");
    access(1, 1, 16'h0003, 16'h00AA, 16'h0000, WR_ST, 0, "both03");
    access(1, 0, 16'h0003, 16'h0000, 16'h00AA, 2, 0, "rd03");
    access(0, 1, 16'h00FF, 16'hFFFF, 16'h0000, WR_ST, 1, "wrFF");
    access(1, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 2, 0, "rdFFFF");
    idle_hold(16'hFFFF);

`ifdef DMEM_POSTED_WRITE_EN
    access(0, 1, 16'h0020, 16'h7777, 16'h0000, 0, 0, "pw20");
    access(1, 0, 16'h0020, 16'h0000, 16'h7777, 2, 0, "prd20");
    access(0, 1, 16'h0021, 16'h1111, 16'h0000, 0, 0, "pw21");
    access(0, 1, 16'h0022, 16'h2222, 16'h0000, 2, 0, "pw22");
    access(1, 0, 16'h0021, 16'h0000, 16'h1111, 2, 0, "prd21");
    access(1, 0, 16'h0022, 16'h0000, 16'h2222, 2, 0, "prd22");
`endif

    @(posedge Clk); #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    bus.Addr     = 16'h0009;
    bus.WrData   = 16'h5555;
    #1;
    chk("rstmid t stall", {31'h0, bus.Stall}, {31'h0, WR_ST != 0});
    @(posedge Clk); #1 Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    bus.MemWrite = 1'b0;
    #1;
    chk("rstmid t+2 stall", {31'h0, bus.Stall}, 32'h0);
    chk("rstmid t+2 valid", {31'h0, bus.RdValid}, 32'h0);
    access(1, 0, 16'h0009, 16'h0000, 16'h0000, 2, 0, "rd09");
    access(1, 0, 16'h0012, 16'h0000, 16'h0000, 2, 0, "rd12clr");

    @(negedge Clk); #1;
    chk("sb empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the MEM stage of the 16-bit pipelined MIPS core; it is the target side of the core's MemRead/MemWrite/address/store-data interface.
- Holds a word-addressed 16-bit RAM with a configurable access latency.
- Asserts Stall back to the pipeline until each access completes, and returns read data with a valid strobe.

Parameters:
- ADDR_W, 8, number of word-address bits; depth = 2**ADDR_W words.
- WAIT_STATES, 2, extra cycles per access (0..15); 0 means single-cycle access.

Ports:
- Clk  input  1  core clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Addr  input  16  word address (ALU result); only Addr[ADDR_W-1:0] is used, upper bits ignored, so addresses wrap.
- WrData  input  16  store data.
- MemRead  input  1  read request.
- MemWrite  input  1  write request.
- RdData  output  16  read data, valid only while RdValid=1.
- RdValid  output  1  one-cycle pulse when read data is valid.
- Stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM while 1.

Behaviour:
- Rst: FSM to IDLE, counter 0, Stall=0, RdValid=0, RdData=0, all RAM words cleared to 0.
- Rst mid-access: any in-flight write is discarded (not committed); no RdValid pulse.
- Request: in IDLE, MemRead|MemWrite at cycle t. Addr, WrData and type are latched at t; later input changes during the access are ignored.
- Both strobes high: treat as a write; the read is dropped and RdValid is not pulsed.
- States: IDLE, WAIT, DONE. W = WAIT_STATES.
- W=0:
  - Read data is combinational in IDLE; RdValid=1 in cycle t.
  - Write commits at the end of cycle t.
  - Stall stays 0.
- W=1: IDLE (Stall=1) -> DONE at t+1.
- W>=2:
  - At t, IDLE asserts Stall=1 and loads cnt=W-1, then moves to WAIT.
  - WAIT: Stall=1; cnt decrements each cycle; WAIT->DONE when cnt==1.
- DONE (cycle t+W):
  - Stall=0.
  - Read: RdValid=1, RdData=mem[addr].
  - Write: commits at the end of t+W; RdValid=0.
  - Next state IDLE.
  - Requests present during DONE are not accepted; the next MEM-stage instruction is seen in IDLE at t+W+1.
- Stall timing:
  - Stall is high for exactly W consecutive cycles, t..t+W-1.
  - Stall is combinational from IDLE and the request inputs in cycle t; registered state thereafter.
- No request in IDLE: Stall=0, RdValid=0, RdData holds its last value.
- Read after write to the same address returns the new value, since the write has committed before the next access starts.

Optional Feature:
- Macro: DMEM_POSTED_WRITE_EN.
- Defined: one-entry posted write buffer (valid, addr, data, own countdown of W cycles).
  - A write in IDLE with an empty buffer is captured with Stall=0 and commits to RAM W cycles later, in the background.
  - A write while the buffer is full stalls until the buffer commits, then is captured.
  - A read whose address matches a valid buffer entry returns buffer data. This also applies if the commit happens in the read's DONE cycle.
  - Reads to other addresses proceed normally in parallel.
  - Rst empties the buffer without committing.
- Undefined: writes take the full stalled path above; the buffer logic is absent.

Test Plan:
- Reset clears RAM: Rst 1 cycle, then read Addr=0x0005 -> RdValid at t+2, RdData=0x0000; Stall high at t and t+1 (W=2).
- Write then read: write 0xBEEF to 0x0012, then read 0x0012 -> Stall 2 cycles per access; RdData=0xBEEF.
- Address wrap (ADDR_W=8): write 0x1234 to 0x0107, read 0x0007 -> RdData=0x1234.
- Simultaneous strobes: MemRead=MemWrite=1, Addr=0x0003, WrData=0x00AA -> no RdValid; a later read of 0x0003 returns 0x00AA.
- Reset mid-access: write 0x5555 to 0x0009 with Rst=1 at t+1 -> Stall=0 at t+2; reading 0x0009 returns 0x0000.
- DMEM_POSTED_WRITE_EN:
  - Write 0x7777 to 0x0020 -> Stall=0 on the write.
  - An immediate read of 0x0020 returns 0x7777.
  - Back-to-back second write stalls 2 cycles.
